// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded MIPS control bits through ID/EX, EX/MEM and MEM/WB; resolves dst, load-use stall, flush.
// Latency: ID bundle on ex_* after 1 cycle, mem_* after 2, wb_* after 3; stall and fwd_* are combinational.
// Backpressure: stall freezes PC/IF-ID externally and bubbles ID/EX; flush bubbles ID/EX and EX/MEM.
// Build option: define FORWARD_UNIT_EN to drive fwd_a/fwd_b; otherwise both are tied to 2'b00.
module ctrl_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            id_reg_dst,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_mem_to_reg,
  input  logic [1:0]            id_alu_op,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic                  mem_branch,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_reg_write,
  output logic [1:0]            mem_mem_to_reg,
  output logic [REG_ADDR_W-1:0] mem_dst,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  localparam logic [REG_ADDR_W-1:0] LINK_DST = REG_ADDR_W'(LINK_REG);
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [1:0]            reg_dst;
    logic                  branch;
    logic                  mem_read;
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_write;
    logic [1:0]            mem_to_reg;
    logic [1:0]            alu_op;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic                  branch;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [1:0]            mem_to_reg;
    logic [REG_ADDR_W-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            mem_to_reg;
    logic [REG_ADDR_W-1:0] dst;
  } memwb_t;

  idex_t  id_ctl;
  idex_t  idex_q;
  exmem_t ex_ctl;
  exmem_t exmem_q;
  memwb_t memwb_q;
  logic [REG_ADDR_W-1:0] ex_dst_res;

  // Sanitize the decoder bundle: don't-care fields of non-writing instructions are stored as 0
  always_comb begin
    id_ctl            = '0;
    id_ctl.reg_dst    = id_reg_write ? id_reg_dst : 2'b00;
    id_ctl.branch     = id_branch;
    id_ctl.mem_read   = id_mem_read;
    id_ctl.mem_write  = id_mem_write;
    id_ctl.alu_src    = (id_reg_write | id_mem_write) ? id_alu_src : 1'b0;
    id_ctl.reg_write  = id_reg_write;
    id_ctl.mem_to_reg = id_reg_write ? id_mem_to_reg : 2'b00;
    id_ctl.alu_op     = (id_reg_write | id_mem_write) ? id_alu_op : 2'b00;
    id_ctl.rs         = id_rs;
    id_ctl.rt         = id_rt;
    id_ctl.rd         = id_rd;
  end

  // Resolve the destination register in EX; a write to r0 is dropped here
  always_comb begin
    ex_dst_res = ZERO_REG;
    case (idex_q.reg_dst)
      2'b00:   ex_dst_res = idex_q.rt;
      2'b01:   ex_dst_res = idex_q.rd;
      2'b10:   ex_dst_res = LINK_DST;
      default: ex_dst_res = ZERO_REG;
    endcase
    ex_ctl            = '0;
    ex_ctl.branch     = idex_q.branch;
    ex_ctl.mem_read   = idex_q.mem_read;
    ex_ctl.mem_write  = idex_q.mem_write;
    ex_ctl.reg_write  = idex_q.reg_write & (ex_dst_res != ZERO_REG);
    ex_ctl.mem_to_reg = idex_q.mem_to_reg;
    ex_ctl.dst        = ex_dst_res;
  end

  // Load-use hazard: the rt compare is applied even for instructions that don't read rt
  assign stall = idex_q.mem_read & (idex_q.rt != ZERO_REG) &
                 ((idex_q.rt == id_rs) | (idex_q.rt == id_rt));

  // ID/EX register: flush or stall loads a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
    end else if (flush || stall) begin
      idex_q <= '0;
    end else begin
      idex_q <= id_ctl;
    end
  end

  // EX/MEM register: flush kills the instruction leaving EX (the branch shadow)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_q <= '0;
    end else if (flush) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= ex_ctl;
    end
  end

  // MEM/WB register: always advances, older instructions complete through a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_q <= '0;
    end else begin
      memwb_q.reg_write  <= exmem_q.reg_write;
      memwb_q.mem_to_reg <= exmem_q.mem_to_reg;
      memwb_q.dst        <= exmem_q.dst;
    end
  end

  assign ex_alu_op      = idex_q.alu_op;
  assign ex_alu_src     = idex_q.alu_src;
  assign ex_rs          = idex_q.rs;
  assign ex_rt          = idex_q.rt;
  assign ex_dst         = ex_dst_res;
  assign mem_branch     = exmem_q.branch;
  assign mem_mem_read   = exmem_q.mem_read;
  assign mem_mem_write  = exmem_q.mem_write;
  assign mem_reg_write  = exmem_q.reg_write;
  assign mem_mem_to_reg = exmem_q.mem_to_reg;
  assign mem_dst        = exmem_q.dst;
  assign wb_reg_write   = memwb_q.reg_write;
  assign wb_mem_to_reg  = memwb_q.mem_to_reg;
  assign wb_dst         = memwb_q.dst;

`ifdef FORWARD_UNIT_EN
  // Operand forward selects: the younger EX/MEM result wins over MEM/WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (exmem_q.reg_write && (exmem_q.dst != ZERO_REG) && (exmem_q.dst == idex_q.rs)) begin
      fwd_a = 2'b10;
    end else if (memwb_q.reg_write && (memwb_q.dst != ZERO_REG) && (memwb_q.dst == idex_q.rs)) begin
      fwd_a = 2'b01;
    end
    if (exmem_q.reg_write && (exmem_q.dst != ZERO_REG) && (exmem_q.dst == idex_q.rt)) begin
      fwd_b = 2'b10;
    end else if (memwb_q.reg_write && (memwb_q.dst != ZERO_REG) && (memwb_q.dst == idex_q.rt)) begin
      fwd_b = 2'b01;
    end
  end
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed instruction sequences with expected outputs queued per cycle.
// A negedge monitor compares every entry due in the current cycle against the DUT.
// Leftover or overdue entries count as failures.
module tb_ctrl_pipe;

  logic       clk;
  logic       rst_n;
  logic [1:0] id_reg_dst;
  logic       id_branch, id_mem_read, id_mem_write, id_alu_src, id_reg_write;
  logic [1:0] id_mem_to_reg, id_alu_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       flush;
  logic       stall;
  logic [1:0] ex_alu_op;
  logic       ex_alu_src;
  logic [4:0] ex_rs, ex_rt, ex_dst;
  logic       mem_branch, mem_mem_read, mem_mem_write, mem_reg_write;
  logic [1:0] mem_mem_to_reg;
  logic [4:0] mem_dst;
  logic       wb_reg_write;
  logic [1:0] wb_mem_to_reg;
  logic [4:0] wb_dst;
  logic [1:0] fwd_a, fwd_b;

`ifdef FORWARD_UNIT_EN
  localparam logic [7:0] FWD_MEM = 8'd2;
  localparam logic [7:0] FWD_WB  = 8'd1;
`else
  localparam logic [7:0] FWD_MEM = 8'd0;
  localparam logic [7:0] FWD_WB  = 8'd0;
`endif

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .id_reg_dst(id_reg_dst), .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .stall(stall),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .mem_branch(mem_branch), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_dst(mem_dst),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  typedef enum int {
    S_STALL, S_EX_ALU_OP, S_EX_ALU_SRC, S_EX_RS, S_EX_RT, S_EX_DST,
    S_MEM_BR, S_MEM_MR, S_MEM_MW, S_MEM_RW, S_MEM_M2R, S_MEM_DST,
    S_WB_RW, S_WB_M2R, S_WB_DST, S_FWD_A, S_FWD_B
  } sig_e;

  typedef struct {
    int         cyc;
    sig_e       sig;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] actual(input sig_e s);
    case (s)
      S_STALL:      return 8'(stall);
      S_EX_ALU_OP:  return 8'(ex_alu_op);
      S_EX_ALU_SRC: return 8'(ex_alu_src);
      S_EX_RS:      return 8'(ex_rs);
      S_EX_RT:      return 8'(ex_rt);
      S_EX_DST:     return 8'(ex_dst);
      S_MEM_BR:     return 8'(mem_branch);
      S_MEM_MR:     return 8'(mem_mem_read);
      S_MEM_MW:     return 8'(mem_mem_write);
      S_MEM_RW:     return 8'(mem_reg_write);
      S_MEM_M2R:    return 8'(mem_mem_to_reg);
      S_MEM_DST:    return 8'(mem_dst);
      S_WB_RW:      return 8'(wb_reg_write);
      S_WB_M2R:     return 8'(wb_mem_to_reg);
      S_WB_DST:     return 8'(wb_dst);
      S_FWD_A:      return 8'(fwd_a);
      default:      return 8'(fwd_b);
    endcase
  endfunction

  // Monitor: retire every expectation due this cycle, away from the active edge
  always @(negedge clk) begin
    exp_t keep[$];
    logic [7:0] got;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        got = actual(sb[i].sig);
        total = total + 1;
        if (got !== sb[i].val) begin
          $display("FAIL %s @cycle %0d: got %0h, expected %0h", sb[i].name, cyc, got, sb[i].val);
        end else begin
          passed = passed + 1;
        end
      end else if (sb[i].cyc < cyc) begin
        total = total + 1;
        $display("FAIL %s @cycle %0d: never sampled, expected %0h", sb[i].name, sb[i].cyc, sb[i].val);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic expect_at(input int off, input sig_e s, input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + off;
    e.sig  = s;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] rdst, input logic br, input logic mr, input logic mw,
                       input logic as, input logic rw, input logic [1:0] m2r, input logic [1:0] aop,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_reg_dst    = rdst;
    id_branch     = br;
    id_mem_read   = mr;
    id_mem_write  = mw;
    id_alu_src    = as;
    id_reg_write  = rw;
    id_mem_to_reg = m2r;
    id_alu_op     = aop;
    id_rs         = rs;
    id_rt         = rt;
    id_rd         = rd;
  endtask

  task automatic nop();
    drive(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    drive(2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b10, rs, rt, rd);
  endtask

  task automatic lw(input logic [4:0] rs, input logic [4:0] rt);
    drive(2'b00, 0, 1, 0, 1, 1, 2'b01, 2'b00, rs, rt, 5'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    nop();
    step();
    // Reset state
    expect_at(0, S_EX_DST, 8'd0, "rst_ex_dst");
    expect_at(0, S_EX_ALU_OP, 8'd0, "rst_ex_alu_op");
    expect_at(0, S_MEM_RW, 8'd0, "rst_mem_rw");
    expect_at(0, S_MEM_DST, 8'd0, "rst_mem_dst");
    expect_at(0, S_WB_RW, 8'd0, "rst_wb_rw");
    expect_at(0, S_WB_DST, 8'd0, "rst_wb_dst");
    expect_at(0, S_STALL, 8'd0, "rst_stall");
    rst_n = 1'b1;
    step();

    // R-format rd=5, addi rt=6, jal: three destination kinds
    rtype(5'd1, 5'd2, 5'd5);
    expect_at(1, S_EX_DST, 8'd5, "r_ex_dst");
    expect_at(1, S_EX_ALU_OP, 8'd2, "r_ex_alu_op");
    expect_at(3, S_WB_DST, 8'd5, "r_wb_dst");
    expect_at(3, S_WB_M2R, 8'd0, "r_wb_m2r");
    expect_at(3, S_WB_RW, 8'd1, "r_wb_rw");
    step();
    drive(2'b00, 0, 0, 0, 1, 1, 2'b00, 2'b00, 5'd1, 5'd6, 5'd9);
    expect_at(1, S_EX_DST, 8'd6, "addi_ex_dst");
    expect_at(1, S_EX_ALU_SRC, 8'd1, "addi_ex_alu_src");
    expect_at(3, S_WB_DST, 8'd6, "addi_wb_dst");
    expect_at(3, S_WB_M2R, 8'd0, "addi_wb_m2r");
    expect_at(3, S_WB_RW, 8'd1, "addi_wb_rw");
    step();
    drive(2'b10, 0, 0, 0, 0, 1, 2'b10, 2'b00, 5'd0, 5'd0, 5'd0);
    expect_at(1, S_EX_DST, 8'd31, "jal_ex_dst");
    expect_at(2, S_MEM_RW, 8'd1, "jal_mem_rw");
    expect_at(3, S_WB_DST, 8'd31, "jal_wb_dst");
    expect_at(3, S_WB_M2R, 8'd2, "jal_wb_m2r");
    expect_at(3, S_WB_RW, 8'd1, "jal_wb_rw");
    step();
    nop();
    step();

    // sw with junk RegDst/MemtoReg, add to r0, reserved RegDst
    drive(2'b10, 0, 0, 1, 1, 0, 2'b01, 2'b00, 5'd1, 5'd4, 5'd0);
    expect_at(1, S_EX_ALU_SRC, 8'd1, "sw_ex_alu_src");
    expect_at(1, S_EX_DST, 8'd4, "sw_ex_dst");
    expect_at(2, S_MEM_MW, 8'd1, "sw_mem_mw");
    expect_at(2, S_MEM_M2R, 8'd0, "sw_mem_m2r");
    expect_at(2, S_MEM_RW, 8'd0, "sw_mem_rw");
    step();
    rtype(5'd2, 5'd3, 5'd0);
    expect_at(2, S_MEM_RW, 8'd0, "add_r0_mem_rw");
    expect_at(2, S_MEM_DST, 8'd0, "add_r0_mem_dst");
    expect_at(3, S_WB_RW, 8'd0, "add_r0_wb_rw");
    step();
    drive(2'b11, 0, 0, 0, 0, 1, 2'b00, 2'b10, 5'd1, 5'd7, 5'd8);
    expect_at(1, S_EX_DST, 8'd0, "rsv_ex_dst");
    expect_at(2, S_MEM_RW, 8'd0, "rsv_mem_rw");
    step();
    nop();
    step();

    // lw rt=8 then add rs=8: one stall cycle, bubble, then add proceeds
    lw(5'd1, 5'd8);
    expect_at(0, S_STALL, 8'd0, "lw_no_stall");
    expect_at(2, S_MEM_MR, 8'd1, "lw_mem_mr");
    expect_at(2, S_MEM_DST, 8'd8, "lw_mem_dst");
    expect_at(3, S_WB_RW, 8'd1, "lw_wb_rw");
    expect_at(3, S_WB_M2R, 8'd1, "lw_wb_m2r");
    step();
    rtype(5'd8, 5'd9, 5'd10);
    expect_at(0, S_STALL, 8'd1, "lu_stall");
    expect_at(1, S_STALL, 8'd0, "lu_stall_once");
    expect_at(1, S_EX_DST, 8'd0, "bubble_ex_dst");
    expect_at(1, S_EX_RS, 8'd0, "bubble_ex_rs");
    expect_at(1, S_EX_RT, 8'd0, "bubble_ex_rt");
    expect_at(1, S_EX_ALU_OP, 8'd0, "bubble_ex_alu_op");
    step();
    rtype(5'd8, 5'd9, 5'd10);
    expect_at(1, S_EX_RS, 8'd8, "add_ex_rs");
    expect_at(1, S_EX_DST, 8'd10, "add_ex_dst");
    expect_at(1, S_MEM_RW, 8'd0, "bubble_mem_rw");
    expect_at(1, S_FWD_A, FWD_WB, "lu_fwd_a");
    expect_at(1, S_FWD_B, 8'd0, "lu_fwd_b");
    expect_at(3, S_WB_DST, 8'd10, "add_wb_dst");
    step();
    nop();
    step();

    // Taken branch in EX flushes the lw in ID; the older addi still retires
    drive(2'b00, 0, 0, 0, 1, 1, 2'b00, 2'b00, 5'd0, 5'd7, 5'd0);
    step();
    drive(2'b11, 1, 0, 0, 0, 0, 2'b11, 2'b01, 5'd1, 5'd2, 5'd0);
    step();
    lw(5'd3, 5'd11);
    flush = 1'b1;
    expect_at(0, S_STALL, 8'd0, "br_no_stall");
    expect_at(1, S_EX_ALU_SRC, 8'd0, "fl_ex_alu_src");
    expect_at(1, S_EX_DST, 8'd0, "fl_ex_dst");
    expect_at(1, S_EX_RT, 8'd0, "fl_ex_rt");
    expect_at(1, S_MEM_BR, 8'd0, "fl_mem_br");
    expect_at(1, S_MEM_RW, 8'd0, "fl_mem_rw");
    expect_at(1, S_MEM_DST, 8'd0, "fl_mem_dst");
    expect_at(1, S_WB_DST, 8'd7, "fl_wb_dst");
    expect_at(1, S_WB_RW, 8'd1, "fl_wb_rw");
    expect_at(2, S_MEM_MR, 8'd0, "fl_lw_killed");
    step();
    flush = 1'b0;
    nop();
    step();

    // Flush and stall together: stall still shown, flush bubbles both stages
    lw(5'd1, 5'd8);
    step();
    rtype(5'd8, 5'd2, 5'd12);
    flush = 1'b1;
    expect_at(0, S_STALL, 8'd1, "fs_stall");
    expect_at(1, S_EX_RS, 8'd0, "fs_ex_rs");
    expect_at(1, S_EX_DST, 8'd0, "fs_ex_dst");
    expect_at(1, S_MEM_MR, 8'd0, "fs_mem_mr");
    expect_at(1, S_MEM_DST, 8'd0, "fs_mem_dst");
    expect_at(1, S_MEM_RW, 8'd0, "fs_mem_rw");
    step();
    flush = 1'b0;
    nop();
    step();

    // Double producer of r3: EX/MEM has priority
    rtype(5'd1, 5'd2, 5'd3);
    step();
    rtype(5'd1, 5'd2, 5'd3);
    step();
    rtype(5'd3, 5'd3, 5'd4);
    expect_at(0, S_STALL, 8'd0, "fw_no_stall");
    expect_at(1, S_FWD_A, FWD_MEM, "fw_fwd_a");
    expect_at(1, S_FWD_B, FWD_MEM, "fw_fwd_b");
    step();

    // Asynchronous reset with every stage occupied
    rtype(5'd1, 5'd2, 5'd5);
    step();
    step();
    expect_at(0, S_EX_DST, 8'd5, "pre_rst_ex_dst");
    step();
    rst_n = 1'b0;
    expect_at(0, S_EX_DST, 8'd0, "arst_ex_dst");
    expect_at(0, S_EX_ALU_OP, 8'd0, "arst_ex_alu_op");
    expect_at(0, S_MEM_DST, 8'd0, "arst_mem_dst");
    expect_at(0, S_MEM_RW, 8'd0, "arst_mem_rw");
    expect_at(0, S_WB_DST, 8'd0, "arst_wb_dst");
    expect_at(0, S_WB_RW, 8'd0, "arst_wb_rw");
    step();
    nop();
    rst_n = 1'b1;
    expect_at(0, S_WB_DST, 8'd0, "post_rst_wb_dst");
    repeat (3) step();

    foreach (sb[i]) begin
      total = total + 1;
      $display("FAIL %s: never checked, expected %0h", sb[i].name, sb[i].val);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Receives the decoded control bundle and register fields in ID. Carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS pipeline.
- Resolves the destination register in EX, detects load-use hazards and inserts bubbles.
- Applies branch flushes.
- Sits between the opcode decoder and the EX/MEM/WB datapath stages.

Parameters:
- REG_ADDR_W, 5, register-number width
- LINK_REG, 31, destination register for RegDst=2'b10 (jal)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_reg_dst  in  2  decoder RegDst (00 rt, 01 rd, 10 link, 11 reserved)
- id_branch, id_mem_read, id_mem_write, id_alu_src, id_reg_write  in  1 each  decoder controls
- id_mem_to_reg  in  2  decoder MemtoReg (00 ALU, 01 mem, 10 PC+4)
- id_alu_op  in  2  decoder ALUOp
- id_rs, id_rt, id_rd  in  REG_ADDR_W  instruction register fields in ID
- flush  in  1  branch taken; kill the instructions in ID and EX
- stall  out  1  combinational load-use hazard; freezes PC and IF/ID externally
- ex_alu_op  out  2; ex_alu_src  out  1; ex_rs, ex_rt, ex_dst  out  REG_ADDR_W
- mem_branch, mem_mem_read, mem_mem_write, mem_reg_write  out  1 each; mem_mem_to_reg  out  2; mem_dst  out  REG_ADDR_W
- wb_reg_write  out  1; wb_mem_to_reg  out  2; wb_dst  out  REG_ADDR_W
- fwd_a, fwd_b  out  2  ALU operand forward selects (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): every stage register and every registered output clears to 0. This is a NOP in all stages. Reset mid-operation discards all in-flight instructions.
- Latency: an ID bundle appears on ex_* 1 cycle later, on mem_* 2 cycles later and on wb_* 3 cycles later.
- Sanitize on ID/EX capture:
  - If id_reg_write=0, reg_dst and mem_to_reg are stored as 0. The x values from sw/beq never propagate.
  - Any x on id_alu_src or id_alu_op while id_reg_write=0 and id_mem_write=0 is stored as 0.
- Destination resolution (ID/EX -> EX/MEM):
  - reg_dst 00 -> ex_rt; 01 -> id_rd captured into ID/EX; 10 -> LINK_REG; 11 -> 0.
  - If the resolved dst is 0, reg_write is forced to 0 into EX/MEM.
- stall = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)). The rt compare is conservative and always applied.
- Stall cycle:
  - ID/EX loads an all-zero bubble.
  - EX/MEM and MEM/WB advance normally.
  - The ID instruction is re-presented by the frozen IF/ID next cycle.
- flush=1: ID/EX and EX/MEM both load bubbles at the next edge. MEM/WB advances normally.
- flush and stall in the same cycle: flush wins. The result is identical bubbles; stall is still asserted for that cycle.
- ex_* and mem_* outputs have no other combinational path from inputs. stall and fwd_* are combinational.

Optional Feature:
- Macro FORWARD_UNIT_EN.
- Defined:
  - fwd_a = 2'b10 if mem_reg_write & mem_dst!=0 & mem_dst==ex_rs.
  - Else fwd_a = 2'b01 if wb_reg_write & wb_dst!=0 & wb_dst==ex_rs.
  - Else fwd_a = 2'b00.
  - fwd_b uses the same rule against ex_rt. EX/MEM has priority over MEM/WB.
- Undefined: fwd_a = fwd_b = 2'b00 constantly, and no compare logic is synthesized. Stall logic is unchanged.

Test Plan:
- Reset: drive R-format (reg_dst 01, reg_write 1), rd=5; pulse rst_n low mid-stream -> all ex_/mem_/wb_ outputs 0 immediately, asynchronously, before the next clk edge.
- R-format rd=5, then addi rt=6, then jal -> on wb_dst over successive cycles: wb_dst=5, wb_dst=6, wb_dst=31; wb_mem_to_reg=00, 00, 10; wb_reg_write=1 each.
- sw with RegDst/MemtoReg=x, then add with rd=0 -> mem_mem_write=1 with mem_mem_to_reg=00 (no x); add reaches MEM with mem_reg_write=0.
- lw rt=8, then add rs=8 -> stall=1 for exactly 1 cycle; the next ex_* bundle is all zero; add then proceeds, and with FORWARD_UNIT_EN fwd_a=01 when add is in EX.
- beq in EX with flush=1 and a lw in ID -> next cycle ex_* and mem_* controls are 0; wb_* still reflects the older instruction.
- FORWARD_UNIT_EN: add rd=3; add rd=3; add rs=3,rt=3 -> fwd_a=fwd_b=10 (EX/MEM priority). Without the macro -> 00.
